// File: rtl/exp_beh_pkg.sv
// Shared defaults and helpers for the exp_beh triple-redundant majority voter.
package exp_beh_pkg;

  localparam int unsigned WIDTH_DEF = 1;
  localparam int unsigned CNT_W_DEF = 8;

  // Saturating +1 for a counter of width w (w <= 32), carried in a 32-bit container.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    if (w >= 32) max_v = 32'hFFFF_FFFF;
    else         max_v = (32'd1 << w) - 32'd1;
    if (v >= max_v) return max_v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/exp_beh_maj3.sv
// Bitwise 2-of-3 majority vote with per-input outvoted lane masks.
module exp_beh_maj3
  import exp_beh_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] mis_a_c,
  output logic [WIDTH-1:0] mis_b_c,
  output logic [WIDTH-1:0] mis_c_c
);

  assign y       = (a & b) | (b & c) | (c & a);
  assign mis_a_c = a ^ y;
  assign mis_b_c = b ^ y;
  assign mis_c_c = c ^ y;

endmodule

// File: rtl/exp_beh.sv
// Registered TMR majority voter with fault flags; EXP_BEH_FAULT_CNT_EN adds
// saturating per-input fault counters (tied to zero when undefined).
module exp_beh
  import exp_beh_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             disagree,
  output logic             fault_a,
  output logic             fault_b,
  output logic             fault_c,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  logic [WIDTH-1:0] maj_c, mis_a_c, mis_b_c, mis_c_c;

  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             dis_q, dis_d;
  logic             fa_q, fa_d, fb_q, fb_d, fc_q, fc_d;

  exp_beh_maj3 #(.WIDTH(WIDTH)) u_maj3 (
    .a       (A),
    .b       (B),
    .c       (C),
    .y       (maj_c),
    .mis_a_c (mis_a_c),
    .mis_b_c (mis_b_c),
    .mis_c_c (mis_c_c)
  );

  // Flags only describe the cycle just sampled; Y alone persists across idle cycles.
  always_comb begin
    y_d     = y_q;
    valid_d = in_valid;
    fa_d    = in_valid & (|mis_a_c);
    fb_d    = in_valid & (|mis_b_c);
    fc_d    = in_valid & (|mis_c_c);
    dis_d   = fa_d | fb_d | fc_d;
    if (in_valid) y_d = maj_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      dis_q   <= 1'b0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      dis_q   <= dis_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
    end
  end

  assign Y         = y_q;
  assign out_valid = valid_q;
  assign disagree  = dis_q;
  assign fault_a   = fa_q;
  assign fault_b   = fb_q;
  assign fault_c   = fc_q;

`ifdef EXP_BEH_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;

  // Each counter advances independently so coincident faults all get recorded.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    if (fa_d) cnt_a_d = CNT_W'(sat_inc(32'(cnt_a_q), CNT_W));
    if (fb_d) cnt_b_d = CNT_W'(sat_inc(32'(cnt_b_q), CNT_W));
    if (fc_d) cnt_c_d = CNT_W'(sat_inc(32'(cnt_c_q), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign err_cnt_a = cnt_a_q;
  assign err_cnt_b = cnt_b_q;
  assign err_cnt_c = cnt_c_q;
`else
  assign err_cnt_a = '0;
  assign err_cnt_b = '0;
  assign err_cnt_c = '0;
`endif

endmodule

// File: tb/tb_exp_beh.sv
// Directed self-checking bench for exp_beh: a WIDTH=1 instance and a WIDTH=4/CNT_W=2 instance.
module tb_exp_beh;

`ifdef EXP_BEH_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1, CNT_W=8 instance
  logic       iv1;
  logic [0:0] a1, b1, c1, y1;
  logic       ov1, dis1, fa1, fb1, fc1;
  logic [7:0] ca1, cb1, cc1;

  // WIDTH=4, CNT_W=2 instance
  logic       iv4;
  logic [3:0] a4, b4, c4, y4;
  logic       ov4, dis4, fa4, fb4, fc4;
  logic [1:0] ca4, cb4, cc4;

  int checks   = 0;
  int failures = 0;

  exp_beh #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1), .C(c1),
    .Y(y1), .out_valid(ov1), .disagree(dis1),
    .fault_a(fa1), .fault_b(fb1), .fault_c(fc1),
    .err_cnt_a(ca1), .err_cnt_b(cb1), .err_cnt_c(cc1)
  );

  exp_beh #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .A(a4), .B(b4), .C(c4),
    .Y(y4), .out_valid(ov4), .disagree(dis4),
    .fault_a(fa4), .fault_b(fb4), .fault_c(fc4),
    .err_cnt_a(ca4), .err_cnt_b(cb4), .err_cnt_c(cc4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv1 = 1'b0; iv4 = 1'b0;
    a1 = '0; b1 = '0; c1 = '0; a4 = '0; b4 = '0; c4 = '0;
    tick(); tick();
    checks++; if (y1 !== 1'b0 || ov1 !== 1'b0 || dis1 !== 1'b0) begin failures++;
      $display("FAIL reset_dut1_out got y=%b ov=%b dis=%b exp 0 0 0", y1, ov1, dis1); end
    checks++; if ({fa1, fb1, fc1} !== 3'b000 || ca1 !== 8'd0 || cb1 !== 8'd0 || cc1 !== 8'd0) begin failures++;
      $display("FAIL reset_dut1_flags got f=%b%b%b cnt=%0d/%0d/%0d exp 000 0/0/0", fa1, fb1, fc1, ca1, cb1, cc1); end
    checks++; if (y4 !== 4'b0 || ov4 !== 1'b0 || dis4 !== 1'b0 || {fa4, fb4, fc4} !== 3'b000) begin failures++;
      $display("FAIL reset_dut4_out got y=%b ov=%b dis=%b f=%b%b%b exp all 0", y4, ov4, dis4, fa4, fb4, fc4); end
    checks++; if (ca4 !== 2'd0 || cb4 !== 2'd0 || cc4 !== 2'd0) begin failures++;
      $display("FAIL reset_dut4_cnt got %0d/%0d/%0d exp 0/0/0", ca4, cb4, cc4); end
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [7:0] ty;
    logic [2:0] v;
    logic       ey, ed;
    ty = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; c1 = v[0];
      tick();
      ey = ty[i];
      ed = (i != 0) && (i != 7);
      checks++; if (y1 !== ey || ov1 !== 1'b1 || dis1 !== ed) begin failures++;
        $display("FAIL truth_%0d got y=%b ov=%b dis=%b exp y=%b ov=1 dis=%b", i, y1, ov1, dis1, ey, ed); end
      checks++; if ({fa1, fb1, fc1} !== {v[2] ^ ey, v[1] ^ ey, v[0] ^ ey}) begin failures++;
        $display("FAIL truth_flags_%0d got %b%b%b exp %b%b%b", i, fa1, fb1, fc1, v[2] ^ ey, v[1] ^ ey, v[0] ^ ey); end
    end
    iv1 = 1'b0;
    // Sweep outvotes A on 011/100, B on 010/101, C on 001/110.
    checks++; if (ca1 !== (CNT_EN ? 8'd2 : 8'd0) || cb1 !== (CNT_EN ? 8'd2 : 8'd0) || cc1 !== (CNT_EN ? 8'd2 : 8'd0)) begin failures++;
      $display("FAIL truth_cnt got %0d/%0d/%0d exp %0d each", ca1, cb1, cc1, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_fault_a();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    tick();
    checks++; if (y1 !== 1'b0 || {fa1, fb1, fc1} !== 3'b100 || dis1 !== 1'b1) begin failures++;
      $display("FAIL fault_a_100 got y=%b f=%b%b%b dis=%b exp y=0 f=100 dis=1", y1, fa1, fb1, fc1, dis1); end
    checks++; if (ca1 !== (CNT_EN ? 8'd1 : 8'd0)) begin failures++;
      $display("FAIL fault_a_cnt1 got %0d exp %0d", ca1, CNT_EN ? 1 : 0); end
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
    tick();
    checks++; if (y1 !== 1'b1 || {fa1, fb1, fc1} !== 3'b100) begin failures++;
      $display("FAIL fault_a_011 got y=%b f=%b%b%b exp y=1 f=100", y1, fa1, fb1, fc1); end
    checks++; if (ca1 !== (CNT_EN ? 8'd2 : 8'd0) || cb1 !== 8'd0 || cc1 !== 8'd0) begin failures++;
      $display("FAIL fault_a_cnt2 got %0d/%0d/%0d exp %0d/0/0", ca1, cb1, cc1, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_hold();
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
    tick(); tick();
    checks++; if (y1 !== 1'b1 || ov1 !== 1'b0 || dis1 !== 1'b0 || {fa1, fb1, fc1} !== 3'b000) begin failures++;
      $display("FAIL hold got y=%b ov=%b dis=%b f=%b%b%b exp y=1 rest 0", y1, ov1, dis1, fa1, fb1, fc1); end
    checks++; if (ca1 !== (CNT_EN ? 8'd2 : 8'd0) || cc1 !== 8'd0) begin failures++;
      $display("FAIL hold_cnt got a=%0d c=%0d exp a=%0d c=0", ca1, cc1, CNT_EN ? 2 : 0); end
  endtask

  task automatic test_multi_lane();
    iv4 = 1'b1; a4 = 4'b0001; b4 = 4'b0010; c4 = 4'b0000;
    tick();
    checks++; if (y4 !== 4'b0000 || {fa4, fb4, fc4} !== 3'b110 || dis4 !== 1'b1 || ov4 !== 1'b1) begin failures++;
      $display("FAIL multi_lane got y=%b f=%b%b%b dis=%b ov=%b exp y=0000 f=110 dis=1 ov=1", y4, fa4, fb4, fc4, dis4, ov4); end
    checks++; if (ca4 !== (CNT_EN ? 2'd1 : 2'd0) || cb4 !== (CNT_EN ? 2'd1 : 2'd0) || cc4 !== 2'd0) begin failures++;
      $display("FAIL multi_lane_cnt got %0d/%0d/%0d exp %0d/%0d/0", ca4, cb4, cc4, CNT_EN ? 1 : 0, CNT_EN ? 1 : 0); end
    a4 = 4'b1111; b4 = 4'b1111; c4 = 4'b1111;
    tick();
    checks++; if (y4 !== 4'b1111 || dis4 !== 1'b0 || {fa4, fb4, fc4} !== 3'b000) begin failures++;
      $display("FAIL unanimous got y=%b dis=%b f=%b%b%b exp y=1111 dis=0 f=000", y4, dis4, fa4, fb4, fc4); end
    checks++; if (ca4 !== (CNT_EN ? 2'd1 : 2'd0) || cb4 !== (CNT_EN ? 2'd1 : 2'd0) || cc4 !== 2'd0) begin failures++;
      $display("FAIL unanimous_cnt got %0d/%0d/%0d exp %0d/%0d/0", ca4, cb4, cc4, CNT_EN ? 1 : 0, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c [5];
    exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
    iv4 = 1'b1; a4 = 4'b0000; b4 = 4'b0000; c4 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cc4 !== (CNT_EN ? exp_c[i] : 2'd0) || fc4 !== 1'b1 || y4 !== 4'b0000) begin failures++;
        $display("FAIL saturate_%0d got cnt_c=%0d fc=%b y=%b exp cnt_c=%0d fc=1 y=0000", i, cc4, fc4, y4, CNT_EN ? exp_c[i] : 2'd0); end
    end
  endtask

  task automatic test_back_to_back();
    a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b1001;
    tick();
    checks++; if (y4 !== 4'b1000 || {fa4, fb4, fc4} !== 3'b111 || dis4 !== 1'b1) begin failures++;
      $display("FAIL b2b_first got y=%b f=%b%b%b dis=%b exp y=1000 f=111 dis=1", y4, fa4, fb4, fc4, dis4); end
    checks++; if (ca4 !== (CNT_EN ? 2'd2 : 2'd0) || cb4 !== (CNT_EN ? 2'd2 : 2'd0) || cc4 !== (CNT_EN ? 2'd3 : 2'd0)) begin failures++;
      $display("FAIL b2b_first_cnt got %0d/%0d/%0d", ca4, cb4, cc4); end
    a4 = 4'b0000; b4 = 4'b1111; c4 = 4'b1111;
    tick();
    checks++; if (y4 !== 4'b1111 || {fa4, fb4, fc4} !== 3'b100 || ov4 !== 1'b1) begin failures++;
      $display("FAIL b2b_second got y=%b f=%b%b%b ov=%b exp y=1111 f=100 ov=1", y4, fa4, fb4, fc4, ov4); end
    checks++; if (ca4 !== (CNT_EN ? 2'd3 : 2'd0) || cb4 !== (CNT_EN ? 2'd2 : 2'd0) || cc4 !== (CNT_EN ? 2'd3 : 2'd0)) begin failures++;
      $display("FAIL b2b_second_cnt got %0d/%0d/%0d", ca4, cb4, cc4); end
    iv4 = 1'b0;
  endtask

  task automatic test_reset_priority();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    rst = 1'b1;
    tick();
    checks++; if (y1 !== 1'b0 || ov1 !== 1'b0 || ca1 !== 8'd0 || cb1 !== 8'd0 || cc1 !== 8'd0) begin failures++;
      $display("FAIL rst_prio got y=%b ov=%b cnt=%0d/%0d/%0d exp 0 0 0/0/0", y1, ov1, ca1, cb1, cc1); end
    checks++; if (y4 !== 4'b0 || ca4 !== 2'd0 || cb4 !== 2'd0 || cc4 !== 2'd0) begin failures++;
      $display("FAIL rst_prio_dut4 got y=%b cnt=%0d/%0d/%0d exp 0", y4, ca4, cb4, cc4); end
    rst = 1'b0;
    tick();
    checks++; if (y1 !== 1'b1 || ov1 !== 1'b1 || dis1 !== 1'b0) begin failures++;
      $display("FAIL post_rst got y=%b ov=%b dis=%b exp 1 1 0", y1, ov1, dis1); end
    iv1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    do_reset();
    test_fault_a();
    test_hold();
    test_multi_lane();
    test_saturate();
    test_back_to_back();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
